// File: rtl/scarv_cop_palu_mshifter_pkg.sv
// Shared encodings for the multi-cycle packed shifter: pack-width codes,
// shift operation encodings and FSM states.
package scarv_cop_palu_mshifter_pkg;

    localparam logic [2:0] SCARV_COP_PW_1  = 3'b001;
    localparam logic [2:0] SCARV_COP_PW_2  = 3'b010;
    localparam logic [2:0] SCARV_COP_PW_4  = 3'b011;
    localparam logic [2:0] SCARV_COP_PW_8  = 3'b100;
    localparam logic [2:0] SCARV_COP_PW_16 = 3'b101;

    typedef enum logic [1:0] {
        OP_SL  = 2'd0,
        OP_SR  = 2'd1,
        OP_ROL = 2'd2,
        OP_SRA = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/scarv_cop_palu_mshift_stage.sv
// One weight-2^J lane-local barrel stage. lw_mask is one-hot over lane widths
// 2/4/8/16/32; lanes no wider than 2^J pass through unchanged.
module scarv_cop_palu_mshift_stage #(
    parameter int XLEN = 32,
    parameter int J    = 0
) (
    input  logic [XLEN-1:0] data,
    input  logic            en,
    input  logic [4:0]      lw_mask,
    input  logic            dir,
    input  logic            rot,
    input  logic            sfill,
    output logic [XLEN-1:0] res
);

    localparam int S = 1 << J;

    logic [4:0][XLEN-1:0] cand;
    logic [XLEN-1:0]      sel;

    genvar gw, gi;
    generate
        for (gw = 0; gw < 5; gw++) begin : g_width
            localparam int LW = 2 << gw;
            if (S >= LW) begin : g_pass
                assign cand[gw] = data;
            end else begin : g_shift
                for (gi = 0; gi < XLEN; gi++) begin : g_bit
                    localparam int O = gi % LW;
                    logic lft;
                    logic rgt;
                    // Bits shifted out of one end of a lane wrap (rotate) or fill.
                    if (O >= S) begin : g_lin
                        assign lft = data[gi-S];
                    end else begin : g_lwrap
                        assign lft = rot & data[gi-S+LW];
                    end
                    if (O + S < LW) begin : g_rin
                        assign rgt = data[gi+S];
                    end else begin : g_rfill
                        assign rgt = sfill & data[gi-O+LW-1];
                    end
                    assign cand[gw][gi] = dir ? lft : rgt;
                end
            end
        end
    endgenerate

    always_comb begin
        sel = '0;
        for (int w = 0; w < 5; w++) begin
            if (lw_mask[w]) sel = sel | cand[w];
        end
        res = en ? sel : data;
    end

endmodule

// File: rtl/scarv_cop_palu_mshifter.sv
// Multi-cycle packed shift/rotate unit; SPC barrel stages per cycle, NCYC cycles.
// Define SCARV_COP_PALU_MSHIFT_ARITH_EN to build the arithmetic right shift.
module scarv_cop_palu_mshifter
    import scarv_cop_palu_mshifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SPC  = 1
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    input  logic            ivalid,
    output logic            iready,
    input  logic [XLEN-1:0] a,
    input  logic [5:0]      shamt,
    input  logic [2:0]      pw,
    input  logic            sl,
    input  logic            r,
    input  logic            ar,
    output logic            ovalid,
    input  logic            oready,
    output logic [XLEN-1:0] c
);

    localparam int         NSTG = 5;
    localparam int         NCYC = (NSTG + SPC - 1) / SPC;
    localparam logic [2:0] LAST = 3'(NCYC - 1);

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg;
    logic [XLEN-1:0] data_reg;
    logic [XLEN-1:0] c_reg;
    logic [4:0]      k_reg;
    logic [4:0]      lw_mask_reg;
    op_t             op_reg;
    logic            zero_reg;

    logic            accept;
    logic            finish;
    logic [2:0]      lwi;
    logic            pw_bad;
    logic [5:0]      lw_m1;
    logic            oor;
    op_t             op_in;
    logic [4:0]      k_in;
    logic            zero_in;

    always_comb begin
        lwi    = 3'd4;
        pw_bad = 1'b0;
        case (pw)
            SCARV_COP_PW_1:  lwi = 3'd4;
            SCARV_COP_PW_2:  lwi = 3'd3;
            SCARV_COP_PW_4:  lwi = 3'd2;
            SCARV_COP_PW_8:  lwi = 3'd1;
            SCARV_COP_PW_16: lwi = 3'd0;
            default:         pw_bad = 1'b1;
        endcase
        lw_m1 = (6'd2 << lwi) - 6'd1;
        oor   = shamt > lw_m1;

        if (r)       op_in = OP_ROL;
        else if (sl) op_in = OP_SL;
`ifdef SCARV_COP_PALU_MSHIFT_ARITH_EN
        else if (ar) op_in = OP_SRA;
`endif
        else         op_in = OP_SR;

        // An out-of-range arithmetic shift by LW-1 leaves every lane full of its sign bit.
        if (op_in == OP_ROL || !oor) k_in = 5'(shamt & lw_m1);
        else if (op_in == OP_SRA)    k_in = 5'(lw_m1);
        else                         k_in = 5'd0;
        zero_in = pw_bad || (oor && op_in != OP_ROL && op_in != OP_SRA);
    end

`ifndef SCARV_COP_PALU_MSHIFT_ARITH_EN
    logic unused_ar;
    assign unused_ar = ar;
`endif

    logic dir;
    logic rot;
    logic sfill;
    assign dir = (op_reg == OP_SL) || (op_reg == OP_ROL);
    assign rot = (op_reg == OP_ROL);
`ifdef SCARV_COP_PALU_MSHIFT_ARITH_EN
    assign sfill = (op_reg == OP_SRA);
`else
    assign sfill = 1'b0;
`endif

    logic [NCYC-1:0][SPC:0][XLEN-1:0] chain;
    logic [XLEN-1:0]                  grp_out;

    genvar gg, gi;
    generate
        for (gg = 0; gg < NCYC; gg++) begin : g_grp
            assign chain[gg][0] = data_reg;
            for (gi = 0; gi < SPC; gi++) begin : g_stg
                localparam int J = gg * SPC + gi;
                if (J < NSTG) begin : g_real
                    scarv_cop_palu_mshift_stage #(
                        .XLEN (XLEN),
                        .J    (J)
                    ) u_stage (
                        .data    (chain[gg][gi]),
                        .en      (k_reg[J]),
                        .lw_mask (lw_mask_reg),
                        .dir     (dir),
                        .rot     (rot),
                        .sfill   (sfill),
                        .res     (chain[gg][gi+1])
                    );
                end else begin : g_thru
                    assign chain[gg][gi+1] = chain[gg][gi];
                end
            end
        end
    endgenerate

    always_comb begin
        grp_out = chain[0][SPC];
        for (int g = 0; g < NCYC; g++) begin
            if (cnt_reg == 3'(g)) grp_out = chain[g][SPC];
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ivalid) begin
                    accept     = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_reg == LAST) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (oready) begin
                    accept     = ivalid;
                    state_next = ivalid ? ST_BUSY : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Flush wins over both a new accept and the result handshake.
        if (flush) begin
            state_next = ST_IDLE;
            accept     = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            data_reg    <= '0;
            c_reg       <= '0;
            k_reg       <= '0;
            lw_mask_reg <= '0;
            op_reg      <= OP_SL;
            zero_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg     <= '0;
                data_reg    <= a;
                k_reg       <= k_in;
                lw_mask_reg <= 5'b00001 << lwi;
                op_reg      <= op_in;
                zero_reg    <= zero_in;
            end else if (flush || finish) begin
                cnt_reg <= '0;
            end else if (state_reg == ST_BUSY) begin
                cnt_reg  <= cnt_reg + 3'd1;
                data_reg <= grp_out;
            end
            if (finish) c_reg <= zero_reg ? '0 : grp_out;
        end
    end

    assign iready = (state_reg == ST_IDLE) || (state_reg == ST_DONE && oready);
    assign ovalid = (state_reg == ST_DONE);
    assign c      = c_reg;

endmodule
